// File: rtl/plic_pkg.sv
// plic_pkg -- definitions shared by the PLIC gateway files.
//   gw_state_e    : per-source gateway lifecycle state
//   PLIC_MAX_SRC  : largest supported number of interrupt sources
//   PLIC_ID_NONE  : the reserved "no source" ID; source i uses ID i+1
package plic_pkg;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_INSERV  = 2'd2
  } gw_state_e;

  localparam int PLIC_MAX_SRC = 63;
  localparam int PLIC_ID_NONE = 0;

endpackage

// File: rtl/plic_gateway_ch.sv
// plic_gateway_ch -- gateway for a single interrupt source.
//   clk, rst   : clock, synchronous active-high reset
//   sig        : interrupt line, already in the clk domain
//   edge_mode  : 1 = edge-triggered, 0 = level-triggered
//   claim      : the core claims this source this cycle (decoded strobe)
//   complete   : the core completes this source this cycle (decoded strobe)
//   state      : registered lifecycle state; also serves as the debug view
//   edge_ovf   : sticky, an edge was lost because the backlog was saturated
//
// Strobe semantics: claim and complete are single-cycle pulses with no
// back-pressure. A strobe that does not match the current state is ignored;
// it is never held or queued.
module plic_gateway_ch
  import plic_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      sig,
  input  logic      edge_mode,
  input  logic      claim,
  input  logic      complete,
  output gw_state_e state,
  output logic      edge_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  gw_state_e        state_nxt;
  logic             prev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             edge_in;
  logic             trigger;
  logic             bump;

  // edge_in only counts as an edge while in edge mode; level mode never
  // touches the backlog.
  assign edge_in = edge_mode & sig & ~prev;
  assign trigger = edge_mode ? edge_in : sig;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ovf_nxt   = edge_ovf;
    bump      = 1'b0;
    case (state)
      GW_IDLE: begin
        if (trigger) state_nxt = GW_PENDING;
      end
      GW_PENDING: begin
        if (claim) state_nxt = GW_INSERV;
        bump = edge_in;
      end
      GW_INSERV: begin
        if (complete) begin
          if (edge_mode) begin
            // An edge on the complete cycle is re-requested straight away,
            // which leaves the backlog as it was (count one, consume one).
            if (edge_in) begin
              state_nxt = GW_PENDING;
            end else if (cnt != '0) begin
              state_nxt = GW_PENDING;
              cnt_nxt   = cnt - 1'b1;
            end else begin
              state_nxt = GW_IDLE;
            end
          end else begin
            state_nxt = sig ? GW_PENDING : GW_IDLE;
          end
        end else begin
          bump = edge_in;
        end
      end
      default: state_nxt = GW_IDLE;
    endcase

    if (bump) begin
      if (cnt == CNT_MAX) ovf_nxt = 1'b1;
      else                cnt_nxt = cnt + 1'b1;
    end

    if (!edge_mode) cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= GW_IDLE;
      prev     <= 1'b0;
      cnt      <= '0;
      edge_ovf <= 1'b0;
    end else begin
      state    <= state_nxt;
      prev     <= sig;
      cnt      <= cnt_nxt;
      edge_ovf <= ovf_nxt;
    end
  end

endmodule

// File: rtl/plic_gateway_array.sv
// plic_gateway_array -- NUM_SRC independent interrupt gateways in front of
// the PLIC priority core.
//   clk, rst      : clock, synchronous active-high reset
//   int_sig       : raw interrupt lines, one per source
//   cfg_edge      : per-source mode, 1 = edge, 0 = level
//   claim_vld/id  : claim strobe and ID (ID i+1 names source i, 0 = none)
//   complete_vld/id: complete strobe and ID
//   int_req       : per-source request to the core (PENDING)
//   in_service    : per-source IN_SERVICE flag
//   edge_ovf      : per-source sticky backlog-overflow flag
// Build option PLIC_GW_SYNC_EN: inserts a 2-flop synchronizer on every
// int_sig bit, for lines coming from another clock domain; request latency
// then grows from 1 to 3 cycles.
module plic_gateway_array
  import plic_pkg::*;
#(
  parameter int NUM_SRC    = 8,
  parameter int EDGE_CNT_W = 3,
  parameter int ID_W       = $clog2(NUM_SRC + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] int_sig,
  input  logic [NUM_SRC-1:0] cfg_edge,
  input  logic               claim_vld,
  input  logic [ID_W-1:0]    claim_id,
  input  logic               complete_vld,
  input  logic [ID_W-1:0]    complete_id,
  output logic [NUM_SRC-1:0] int_req,
  output logic [NUM_SRC-1:0] in_service,
  output logic [NUM_SRC-1:0] edge_ovf
);

  logic [NUM_SRC-1:0] sig_s;

`ifdef PLIC_GW_SYNC_EN
  logic [NUM_SRC-1:0] sync_q1;
  logic [NUM_SRC-1:0] sync_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= int_sig;
      sync_q2 <= sync_q1;
    end
  end

  assign sig_s = sync_q2;
`else
  assign sig_s = int_sig;
`endif

  // ID 0 never matches a source, and IDs above NUM_SRC fall out of the
  // decode on their own since no channel carries them.
  logic claim_ok;
  logic complete_ok;

  assign claim_ok    = claim_vld    && (claim_id    != ID_W'(PLIC_ID_NONE));
  assign complete_ok = complete_vld && (complete_id != ID_W'(PLIC_ID_NONE));

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    gw_state_e ch_state;
    logic      claim_hit;
    logic      complete_hit;

    assign claim_hit    = claim_ok    && (claim_id    == ID_W'(i + 1));
    assign complete_hit = complete_ok && (complete_id == ID_W'(i + 1));

    plic_gateway_ch #(
      .CNT_W (EDGE_CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .sig       (sig_s[i]),
      .edge_mode (cfg_edge[i]),
      .claim     (claim_hit),
      .complete  (complete_hit),
      .state     (ch_state),
      .edge_ovf  (edge_ovf[i])
    );

    // Pure decode of a registered state, so outputs stay registered.
    assign int_req[i]    = (ch_state == GW_PENDING);
    assign in_service[i] = (ch_state == GW_INSERV);
  end

endmodule
